// File: rtl/sigma_mem_pkg.sv
// sigma_mem_pkg: shared state encoding and word/lane geometry for the Sigma bench RAM
package sigma_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
  localparam int BYTE_LANES = 4;
  localparam int WORD_BITS = 32;
  localparam int LANE_BITS = WORD_BITS / BYTE_LANES;
endpackage

// File: rtl/wait_state_memory_if.sv
// wait_state_memory_if: CPU-side request/ready bus, big-endian bit numbering throughout
interface wait_state_memory_if #(
  parameter int ADDR_BITS = 17
);
  logic req;
  logic [32-ADDR_BITS:31] address;
  logic [0:3] write_en;
  logic [0:31] data_in;
  logic [0:31] data_out;
  logic ready;
  logic fault;
  modport master (output req, address, write_en, data_in, input data_out, ready, fault);
  modport slave (input req, address, write_en, data_in, output data_out, ready, fault);
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable 4-bit down-counter that flags the last wait cycle
module mem_wait_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] value,
  output logic       done
);
  always_ff @(posedge clock or posedge reset)
    if (reset) value <= '0;
    else if (load) value <= load_value;
    else if (value != 4'd0) value <= value - 4'd1;
  assign done = value == 4'd1;
endmodule

// File: rtl/wait_state_memory.sv
// wait_state_memory: Sigma CPU bench RAM with byte lanes, programmable wait states and range fault
module wait_state_memory
  import sigma_mem_pkg::*;
#(
  parameter int ADDR_BITS  = 17,
  parameter int DEPTH      = 128,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 0
) (
  input logic clock,
  input logic reset,
  wait_state_memory_if.slave bus
);
  localparam int IDX_BITS = DEPTH > 1 ? $clog2(DEPTH) : 1;
  mem_state_t state, state_n;
  logic [32-ADDR_BITS:31] addr_l;
  logic [0:BYTE_LANES-1] we_l;
  logic [0:WORD_BITS-1] din_l, word;
  logic [32-IDX_BITS:31] idx;
  logic oor, wr, cnt_load, cnt_done;
  logic [3:0] cnt_init, cnt_val;
  assign idx = addr_l[32-IDX_BITS:31];
  assign oor = 32'(addr_l) >= 32'(DEPTH);
  assign wr = state == DONE && !oor;
  assign cnt_load = state == IDLE && bus.req;
  assign cnt_init = |bus.write_en ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
  mem_wait_counter u_cnt (
    .clock(clock),
    .reset(reset),
    .load(cnt_load),
    .load_value(cnt_init),
    .value(cnt_val),
    .done(cnt_done)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = bus.req ? (cnt_init != 4'd0 ? WAIT : DONE) : IDLE;
    else state_n = state == WAIT ? (cnt_done || cnt_val == 4'd0 ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.ready <= 1'b0;
      bus.fault <= 1'b0;
      bus.data_out <= '0;
    end else begin
      state <= state_n;
      bus.ready <= state == DONE;
      bus.fault <= state == DONE && oor;
      bus.data_out <= wr ? word : '0;
    end
  always_ff @(posedge clock)
    if (cnt_load) begin
      addr_l <= bus.address;
      we_l <= bus.write_en;
      din_l <= bus.data_in;
    end
  // word is the post-write view so a write's ready cycle returns the merged result
  for (genvar l = 0; l < BYTE_LANES; l++) begin : g_lane
    logic [LANE_BITS-1:0] mem [DEPTH];
    always_ff @(posedge clock)
      if (wr && we_l[l]) mem[idx] <= din_l[l*LANE_BITS +: LANE_BITS];
    assign word[l*LANE_BITS +: LANE_BITS] = we_l[l] ? din_l[l*LANE_BITS +: LANE_BITS] : mem[idx];
  end
endmodule
